pio_tctrl_ndev: RTL and testbench

Parametrised successor to the single-device PIO timing controller. It sequences ATA PIO read and write cycles (T1 setup, T2 strobe, IORDY wait, T4 hold and end-of-cycle recovery) for up to NDEV devices, each with its own timing set. It adds three things the single-device controller lacks: a per-device fallback to PIO mode-0 timing, an IORDY timeout with an error flag, and a one-deep pending request. It sits between the host register and command logic and the ATA pins.

---
 rtl/pio_pkg.sv | 29 ++
 rtl/pio_dcnt.sv | 28 ++
 rtl/pio_tctrl_ndev.sv | 247 ++++++++++++++++++++++++
 tb/tb_pio_tctrl_ndev.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared types and constants for the multi-device ATA PIO timing controller.
// Also holds the helper that pulls one device's field out of a packed vector.
package pio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAITRDY,
        ST_RECOVER
    } pio_state_e;

    localparam int PIO_M0_T1   = 6;
    localparam int PIO_M0_T2   = 28;
    localparam int PIO_M0_T4   = 2;
    localparam int PIO_M0_TEOC = 23;

    // Widest packed timing vector the field helper accepts (NDEV*TWIDTH).
    localparam int PIO_VEC_W = 512;

    function automatic logic [31:0] pio_field(input logic [PIO_VEC_W-1:0] vec,
                                              input int unsigned idx,
                                              input int unsigned w);
        logic [PIO_VEC_W-1:0] sh;
        sh = vec >> (idx * w);
        return sh[31:0];
    endfunction

endpackage

// File: rtl/pio_dcnt.sv
// Loadable down-counter. done_o is high once the count has reached its last tick
// and stays high (the count saturates) until the next load.
module pio_dcnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/pio_tctrl_ndev.sv
// ATA PIO cycle sequencer for NDEV devices: per-device timings with mode-0
// fallback, IORDY stretch with optional timeout, and a one-deep request slot.
module pio_tctrl_ndev
    import pio_pkg::*;
#(
    parameter int TWIDTH       = 8,
    parameter int NDEV         = 2,
    parameter int TOWIDTH      = 16,
    parameter int PIO_MODE0_T1   = PIO_M0_T1,
    parameter int PIO_MODE0_T2   = PIO_M0_T2,
    parameter int PIO_MODE0_T4   = PIO_M0_T4,
    parameter int PIO_MODE0_Teoc = PIO_M0_TEOC,
    localparam int DSW = (NDEV > 1) ? $clog2(NDEV) : 1
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic [NDEV*TWIDTH-1:0] T1,
    input  logic [NDEV*TWIDTH-1:0] T2,
    input  logic [NDEV*TWIDTH-1:0] T4,
    input  logic [NDEV*TWIDTH-1:0] Teoc,
    input  logic [NDEV-1:0]        tvalid,
    input  logic [NDEV-1:0]        IORDY_en,
    input  logic [TOWIDTH-1:0]     tmo,
    input  logic                   go,
    input  logic                   we,
    input  logic [DSW-1:0]         dev,
    output logic                   busy,
    output logic                   oe,
    output logic                   dstrb,
    output logic                   done,
    output logic                   tmo_err,
    output logic                   DIOR,
    output logic                   DIOW,
    input  logic                   IORDY
);

    localparam int CW = (TWIDTH > TOWIDTH) ? TWIDTH : TOWIDTH;

    function automatic logic [TWIDTH-1:0] nz(input logic [TWIDTH-1:0] x);
        return (x == '0) ? TWIDTH'(1) : x;
    endfunction

    pio_state_e         state_q;
    logic               pend_v_q, pend_we_q;
    logic [DSW-1:0]     pend_dev_q;
    logic               we_q, iordy_en_q, timedout_q, t4_fired_q;
    logic [TWIDTH-1:0]  t2_q, t4_q, teoc_q;
    logic [TOWIDTH-1:0] tmo_q;
    logic               busy_q, oe_q, dstrb_q, done_q, tmo_err_q, dior_q, diow_q;

    logic [PIO_VEC_W-1:0] t1_v, t2_v, t4_v, teoc_v;
    logic [NDEV-1:0]      vmask, rmask;
    logic                 start, start_we, sel_valid, sel_iordy;
    logic [DSW-1:0]       start_dev;
    logic [TWIDTH-1:0]    sel_t1, sel_t2, sel_t4, sel_teoc;
    logic                 ph_load, ph_en, rc_load, rc_en, tmo_hit;
    logic [CW-1:0]        ph_val;
    logic                 ph_done, t4_done, eoc_done;

    assign t1_v   = PIO_VEC_W'(T1);
    assign t2_v   = PIO_VEC_W'(T2);
    assign t4_v   = PIO_VEC_W'(T4);
    assign teoc_v = PIO_VEC_W'(Teoc);

    // A pending request takes priority over a fresh go in IDLE.
    always_comb begin
        start     = 1'b0;
        start_we  = we;
        start_dev = dev;
        if (state_q == ST_IDLE) begin
            if (pend_v_q) begin
                start     = 1'b1;
                start_we  = pend_we_q;
                start_dev = pend_dev_q;
            end else if (go) begin
                start = 1'b1;
            end
        end
        vmask     = tvalid >> start_dev;
        rmask     = IORDY_en >> start_dev;
        sel_valid = vmask[0];
        sel_iordy = rmask[0];
        sel_t1   = nz(sel_valid ? TWIDTH'(pio_field(t1_v, 32'(start_dev), TWIDTH))
                                : TWIDTH'(PIO_MODE0_T1));
        sel_t2   = nz(sel_valid ? TWIDTH'(pio_field(t2_v, 32'(start_dev), TWIDTH))
                                : TWIDTH'(PIO_MODE0_T2));
        sel_t4   = nz(sel_valid ? TWIDTH'(pio_field(t4_v, 32'(start_dev), TWIDTH))
                                : TWIDTH'(PIO_MODE0_T4));
        sel_teoc = nz(sel_valid ? TWIDTH'(pio_field(teoc_v, 32'(start_dev), TWIDTH))
                                : TWIDTH'(PIO_MODE0_Teoc));
    end

    // The phase counter is reloaded at each SETUP/STROBE/WAITRDY boundary.
    always_comb begin
        ph_load = 1'b0;
        ph_val  = '0;
        ph_en   = 1'b0;
        rc_load = 1'b0;
        tmo_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ph_load = 1'b1;
                    ph_val  = CW'(sel_t1);
                end
            end
            ST_SETUP: begin
                ph_en = 1'b1;
                if (ph_done) begin
                    ph_load = 1'b1;
                    ph_val  = CW'(t2_q);
                end
            end
            ST_STROBE: begin
                ph_en = 1'b1;
                if (ph_done) begin
                    if (iordy_en_q && !IORDY) begin
                        ph_load = 1'b1;
                        ph_val  = CW'(tmo_q);
                    end else begin
                        rc_load = 1'b1;
                    end
                end
            end
            ST_WAITRDY: begin
                ph_en = 1'b1;
                if (IORDY) begin
                    rc_load = 1'b1;
                end else if ((tmo_q != '0) && ph_done) begin
                    rc_load = 1'b1;
                    tmo_hit = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign rc_en = (state_q == ST_RECOVER);

    pio_dcnt #(.W(CW)) u_phase (
        .clk(clk), .nReset(nReset), .load_i(ph_load), .val_i(ph_val),
        .en_i(ph_en), .done_o(ph_done)
    );

    pio_dcnt #(.W(TWIDTH)) u_teoc (
        .clk(clk), .nReset(nReset), .load_i(rc_load), .val_i(teoc_q),
        .en_i(rc_en), .done_o(eoc_done)
    );

    pio_dcnt #(.W(TWIDTH)) u_t4 (
        .clk(clk), .nReset(nReset), .load_i(rc_load), .val_i(t4_q),
        .en_i(rc_en), .done_o(t4_done)
    );

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q    <= ST_IDLE;
            pend_v_q   <= 1'b0;
            pend_we_q  <= 1'b0;
            pend_dev_q <= '0;
            we_q       <= 1'b0;
            iordy_en_q <= 1'b0;
            timedout_q <= 1'b0;
            t4_fired_q <= 1'b0;
            t2_q       <= '0;
            t4_q       <= '0;
            teoc_q     <= '0;
            tmo_q      <= '0;
            busy_q     <= 1'b0;
            oe_q       <= 1'b0;
            dstrb_q    <= 1'b0;
            done_q     <= 1'b0;
            tmo_err_q  <= 1'b0;
            dior_q     <= 1'b0;
            diow_q     <= 1'b0;
        end else begin
            dstrb_q   <= 1'b0;
            done_q    <= 1'b0;
            tmo_err_q <= 1'b0;

            if ((state_q == ST_IDLE) && pend_v_q) begin
                pend_v_q <= 1'b0;
            end else if (go && (state_q != ST_IDLE) && !pend_v_q) begin
                pend_v_q   <= 1'b1;
                pend_we_q  <= we;
                pend_dev_q <= dev;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_SETUP;
                        we_q       <= start_we;
                        iordy_en_q <= sel_iordy;
                        t2_q       <= sel_t2;
                        t4_q       <= sel_t4;
                        teoc_q     <= sel_teoc;
                        tmo_q      <= tmo;
                        busy_q     <= 1'b1;
                        oe_q       <= start_we;
                    end
                end
                ST_SETUP: begin
                    if (ph_done) begin
                        state_q <= ST_STROBE;
                        dior_q  <= !we_q;
                        diow_q  <= we_q;
                    end
                end
                ST_STROBE, ST_WAITRDY: begin
                    if (rc_load) begin
                        state_q    <= ST_RECOVER;
                        dior_q     <= 1'b0;
                        diow_q     <= 1'b0;
                        dstrb_q    <= !we_q;
                        timedout_q <= tmo_hit;
                        t4_fired_q <= 1'b0;
                    end else if ((state_q == ST_STROBE) && ph_done) begin
                        state_q <= ST_WAITRDY;
                    end
                end
                ST_RECOVER: begin
                    if (t4_done && !t4_fired_q) begin
                        done_q     <= 1'b1;
                        tmo_err_q  <= timedout_q;
                        oe_q       <= 1'b0;
                        t4_fired_q <= 1'b1;
                    end
                    if (t4_done && eoc_done) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign oe      = oe_q;
    assign dstrb   = dstrb_q;
    assign done    = done_q;
    assign tmo_err = tmo_err_q;
    assign DIOR    = dior_q;
    assign DIOW    = diow_q;

endmodule

// File: tb/tb_pio_tctrl_ndev.sv
// Directed bench for pio_tctrl_ndev: each scenario records 64 edges of output
// traces (bit k = value just after edge k) and compares them to hand-built windows.
module tb_pio_tctrl_ndev;

    localparam int TW  = 8;
    localparam int ND  = 2;
    localparam int TOW = 16;

    logic              clk = 1'b0;
    logic              nReset;
    logic [ND*TW-1:0]  T1, T2, T4, Teoc;
    logic [ND-1:0]     tvalid, IORDY_en;
    logic [TOW-1:0]    tmo;
    logic              go, we;
    logic [0:0]        dev;
    logic              busy, oe, dstrb, done, tmo_err, DIOR, DIOW;
    logic              IORDY;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] tr_busy, tr_oe, tr_dstrb, tr_done, tr_tmoe, tr_dior, tr_diow;

    always #5 clk = ~clk;

    pio_tctrl_ndev #(.TWIDTH(TW), .NDEV(ND), .TOWIDTH(TOW)) dut (
        .clk(clk), .nReset(nReset), .T1(T1), .T2(T2), .T4(T4), .Teoc(Teoc),
        .tvalid(tvalid), .IORDY_en(IORDY_en), .tmo(tmo), .go(go), .we(we),
        .dev(dev), .busy(busy), .oe(oe), .dstrb(dstrb), .done(done),
        .tmo_err(tmo_err), .DIOR(DIOR), .DIOW(DIOW), .IORDY(IORDY)
    );

    function automatic logic [63:0] win(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int k = 0; k < 64; k++) if (k >= lo && k < hi) m[k] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Edge 0 is the first posedge after the call; caller presets we/dev.
    task automatic run(input int iordy_rise,
                       input int g2k, input logic g2we, input logic g2dev,
                       input int g3k, input logic g3we, input logic g3dev,
                       input int rk);
        go    = 1'b1;
        IORDY = (0 >= iordy_rise);
        for (int k = 0; k < 64; k++) begin
            @(posedge clk);
            #1;
            tr_busy[k]  = busy;
            tr_oe[k]    = oe;
            tr_dstrb[k] = dstrb;
            tr_done[k]  = done;
            tr_tmoe[k]  = tmo_err;
            tr_dior[k]  = DIOR;
            tr_diow[k]  = DIOW;
            go     = 1'b0;
            nReset = 1'b1;
            if (k + 1 == g2k) begin go = 1'b1; we = g2we; dev = g2dev; end
            if (k + 1 == g3k) begin go = 1'b1; we = g3we; dev = g3dev; end
            if (k + 1 == rk) nReset = 1'b0;
            IORDY = (k + 1 >= iordy_rise);
        end
    endtask

    initial begin
        nReset = 1'b0; go = 1'b0; we = 1'b0; dev = 1'b0; IORDY = 1'b1;
        T1 = '0; T2 = '0; T4 = '0; Teoc = '0;
        tvalid = 2'b11; IORDY_en = 2'b00; tmo = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({busy, oe, dstrb, done, tmo_err, DIOR, DIOW}), 64'd0);
        nReset = 1'b1;

        // Read on dev0, no IORDY wait
        T1 = {8'd9, 8'd3}; T2 = {8'd9, 8'd5}; T4 = {8'd9, 8'd2}; Teoc = {8'd9, 8'd6};
        we = 1'b0; dev = 1'b0;
        run(0, -1, 1'b0, 1'b0, -1, 1'b0, 1'b0, -1);
        chk("rd_dior",  tr_dior,  win(3, 8));
        chk("rd_diow",  tr_diow,  64'd0);
        chk("rd_dstrb", tr_dstrb, win(8, 9));
        chk("rd_done",  tr_done,  win(10, 11));
        chk("rd_busy",  tr_busy,  win(0, 14));
        chk("rd_oe",    tr_oe,    64'd0);

        // Write on dev1 stretched by IORDY until edge 12
        T1 = {8'd2, 8'd3}; T2 = {8'd4, 8'd5}; T4 = {8'd3, 8'd2}; Teoc = {8'd5, 8'd6};
        IORDY_en = 2'b10; tmo = '0;
        we = 1'b1; dev = 1'b1;
        run(12, -1, 1'b0, 1'b0, -1, 1'b0, 1'b0, -1);
        chk("wr_diow",  tr_diow,  win(2, 12));
        chk("wr_dior",  tr_dior,  64'd0);
        chk("wr_oe",    tr_oe,    win(0, 15));
        chk("wr_dstrb", tr_dstrb, 64'd0);
        chk("wr_done",  tr_done,  win(15, 16));
        chk("wr_tmoe",  tr_tmoe,  64'd0);
        chk("wr_busy",  tr_busy,  win(0, 17));

        // IORDY timeout on a dev1 read
        tmo = 16'd10;
        we = 1'b0; dev = 1'b1;
        run(1000, -1, 1'b0, 1'b0, -1, 1'b0, 1'b0, -1);
        chk("to_dior",  tr_dior,  win(2, 16));
        chk("to_dstrb", tr_dstrb, win(16, 17));
        chk("to_done",  tr_done,  win(19, 20));
        chk("to_tmoe",  tr_tmoe,  win(19, 20));
        chk("to_busy",  tr_busy,  win(0, 21));

        // Mode-0 fallback on dev0
        tmo = '0; IORDY_en = 2'b00; tvalid = 2'b10;
        we = 1'b0; dev = 1'b0;
        run(0, -1, 1'b0, 1'b0, -1, 1'b0, 1'b0, -1);
        chk("m0_dior",  tr_dior,  win(6, 34));
        chk("m0_dstrb", tr_dstrb, win(34, 35));
        chk("m0_done",  tr_done,  win(36, 37));
        chk("m0_busy",  tr_busy,  win(0, 57));

        // All-zero timings act as 1
        tvalid = 2'b11;
        T1 = {8'd9, 8'd0}; T2 = {8'd9, 8'd0}; T4 = {8'd9, 8'd0}; Teoc = {8'd9, 8'd0};
        we = 1'b0; dev = 1'b0;
        run(0, -1, 1'b0, 1'b0, -1, 1'b0, 1'b0, -1);
        chk("z_dior",  tr_dior,  win(1, 2));
        chk("z_dstrb", tr_dstrb, win(2, 3));
        chk("z_done",  tr_done,  win(3, 4));
        chk("z_busy",  tr_busy,  win(0, 3));

        // Pending request: write dev0, read dev1 queued in STROBE, third go dropped
        T1 = {8'd3, 8'd2}; T2 = {8'd2, 8'd3}; T4 = {8'd2, 8'd1}; Teoc = {8'd2, 8'd4};
        we = 1'b1; dev = 1'b0;
        run(0, 3, 1'b0, 1'b1, 7, 1'b1, 1'b0, -1);
        chk("pd_busy",  tr_busy,  win(0, 9) | win(10, 17));
        chk("pd_diow",  tr_diow,  win(2, 5));
        chk("pd_dior",  tr_dior,  win(13, 15));
        chk("pd_oe",    tr_oe,    win(0, 6));
        chk("pd_dstrb", tr_dstrb, win(15, 16));
        chk("pd_done",  tr_done,  win(6, 7) | win(17, 18));

        // Reset at edge 5 of a write with a read already pending
        T1 = {8'd3, 8'd3}; T2 = {8'd5, 8'd5}; T4 = {8'd2, 8'd2}; Teoc = {8'd6, 8'd6};
        we = 1'b1; dev = 1'b0;
        run(0, 2, 1'b0, 1'b1, -1, 1'b0, 1'b0, 5);
        chk("rs_busy", tr_busy, win(0, 5));
        chk("rs_diow", tr_diow, win(3, 5));
        chk("rs_oe",   tr_oe,   win(0, 5));
        chk("rs_done", tr_done, 64'd0);
        chk("rs_dior", tr_dior, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
